// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit that owns the HI/LO pair. Each multiply or
// divide takes one shift-add or restoring-divide step per cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [6:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [6:0] OP_DIV   = 7'd7;
  localparam logic [6:0] OP_DIVU  = 7'd8;
  localparam logic [6:0] OP_MTHI  = 7'd11;
  localparam logic [6:0] OP_MTLO  = 7'd12;
  localparam logic [6:0] OP_MULT  = 7'd13;
  localparam logic [6:0] OP_MULTU = 7'd14;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            is_div;
  logic            neg_q;
  logic            neg_r;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic             is_signed;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    abs_a     = (is_signed && a[WIDTH-1]) ? -a : a;
    abs_b     = (is_signed && b[WIDTH-1]) ? -b : b;
    // Multiply: acc_hi:acc_lo holds partial product over the remaining multiplier bits.
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    prod_fix  = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo_fix   = neg_q ? -acc_lo : acc_lo;
    rem_fix   = neg_r ? -acc_hi : acc_hi;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; done defaults low so it pulses for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opb    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MTHI: begin
                hi   <= a;
                done <= 1'b1;
              end
              OP_MTLO: begin
                lo   <= a;
                done <= 1'b1;
              end
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                is_div <= (op == OP_DIV) || (op == OP_DIVU);
                neg_q  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r  <= is_signed & a[WIDTH-1];
                acc_hi <= '0;
                acc_lo <= abs_a;
                opb    <= abs_b;
                cnt    <= '0;
                busy   <= 1'b1;
                state  <= RUN;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (is_div) begin
            if (!div_diff[WIDTH]) begin
              acc_hi <= div_diff[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FINISH;
        end
        FINISH: begin
          if (is_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO from an
// arithmetic reference model, a monitor pops and compares on every done pulse.
module tb_mult_div_unit;

  localparam logic [6:0] OP_DIV   = 7'd7;
  localparam logic [6:0] OP_DIVU  = 7'd8;
  localparam logic [6:0] OP_MTHI  = 7'd11;
  localparam logic [6:0] OP_MTLO  = 7'd12;
  localparam logic [6:0] OP_MULT  = 7'd13;
  localparam logic [6:0] OP_MULTU = 7'd14;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hl_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int  checks = 0;
  int  failures = 0;
  hl_t exp_q[$];
  hl_t model = '0;
  hl_t committed = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic hl_t ref_model(input logic [6:0] o, input logic [31:0] x,
                                    input logic [31:0] y, input hl_t cur);
    hl_t    r = cur;
    longint sx = $signed(x);
    longint sy = $signed(y);
    logic [63:0] up;
    case (o)
      OP_MTHI: r.hi = x;
      OP_MTLO: r.lo = x;
      OP_MULTU: begin
        up = {32'b0, x} * {32'b0, y};
        r  = hl_t'(up);
      end
      OP_MULT: r = hl_t'(sx * sy);
      OP_DIVU: begin
        if (y == 0) begin r.lo = 32'hFFFF_FFFF; r.hi = x; end
        else begin r.lo = x / y; r.hi = x % y; end
      end
      OP_DIV: begin
        if (y == 0) begin
          r.lo = (sx < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF;
          r.hi = x;
        end else begin
          r.lo = 32'(sx / sy);
          r.hi = 32'(sx % sy);
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  // Issue one request and wait for its done; inject_at >= 0 fires a DIVU
  // request at that many cycles after acceptance, which must be ignored.
  task automatic issue(input logic [6:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int inject_at);
    bit iter = (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
    bit busy_ok = 1'b1;
    int lat = 0;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    model = ref_model(o, x, y, model);
    exp_q.push_back(model);
    @(negedge clk);
    start = 1'b0;
    while (!done && lat < 40) begin
      if (busy !== iter) busy_ok = 1'b0;
      if (lat == inject_at) begin
        start = 1'b1; op = OP_DIVU; a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("latency", 64'(lat), iter ? 64'd33 : 64'd0);
    check("busy_during_op", 64'(busy_ok), 64'd1);
    check("busy_after_done", 64'(busy), 64'd0);
  endtask

  // Scoreboard monitor: samples one time unit after every rising edge.
  initial begin
    hl_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        exp_q.delete();
        committed = '0;
      end else if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("result_hi_lo", {hi, lo}, e);
          committed = e;
        end
      end else begin
        check("hold_hi_lo", {hi, lo}, committed);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] ops[6] = '{OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU};
    logic [6:0] ro;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    check("reset_state", {30'b0, busy, done, hi, lo}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {31'b0, busy, 32'b0}, 64'd0);

    // Directed cases from the boundary list.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    issue(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, -1);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, -1);
    issue(OP_DIVU,  32'h0000_0005, 32'h0000_0000, -1);
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1);
    issue(OP_DIV,   32'h8000_0005, 32'h0000_0000, -1);
    issue(OP_DIV,   32'h0000_0009, 32'h0000_0000, -1);
    issue(OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, -1);

    // Back-to-back MTHI then MTLO on consecutive cycles.
    @(negedge clk);
    op = OP_MTHI; a = 32'h1234_5678; start = 1'b1;
    model = ref_model(OP_MTHI, 32'h1234_5678, 32'h0, model);
    exp_q.push_back(model);
    @(negedge clk);
    check("mthi_done_busy", {62'b0, done, busy}, 64'd2);
    op = OP_MTLO; a = 32'h9ABC_DEF0;
    model = ref_model(OP_MTLO, 32'h9ABC_DEF0, 32'h0, model);
    exp_q.push_back(model);
    @(negedge clk);
    start = 1'b0;
    check("mtlo_done_busy", {62'b0, done, busy}, 64'd2);
    @(negedge clk);
    check("mt_pair_quiet", {62'b0, done, busy}, 64'd0);

    // A request arriving while busy must be dropped.
    issue(OP_MULTU, 32'h0001_2345, 32'h0006_789A, 9);
    repeat (3) @(negedge clk);

    // Unlisted opcode is ignored.
    op = 7'd5; a = 32'hDEAD_BEEF; b = 32'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      check("bad_op_ignored", {62'b0, done, busy}, 64'd0);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a divide.
    op = OP_DIV; a = 32'h7654_3210; b = 32'h0000_0123; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check("busy_before_reset", 64'(busy), 64'd1);
    reset = 1'b0;
    model = '0;
    #1;
    check("async_reset_clears", {30'b0, busy, done, hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, -1);

    // Randomized traffic with a bias toward the divide corner cases.
    for (int i = 0; i < 40; i++) begin
      ro = ops[$urandom_range(5, 0)];
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(7, 0))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(15, 1);
        default: ;
      endcase
      issue(ro, ra, rb, -1);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multiply/divide engine that owns the HI/LO register pair. It answers MULT/MULTU/DIV/DIVU/MTHI/MTLO requests issued by the datapath through a start/busy/done handshake and presents HI/LO for MFHI/MFLO reads. Operation: one shift-add or restoring-divide step per cycle, so no single-cycle 64-bit multiplier or 32-bit divider is needed.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits and the iteration count equals WIDTH.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
start  input  1  request strobe; sampled on the rising edge.
op  input  7  operation code using the CPU opcode numbering: DIV=7, DIVU=8, MTHI=11, MTLO=12, MULT=13, MULTU=14.
a  input  WIDTH  multiplicand/dividend, or the MTHI/MTLO source.
b  input  WIDTH  multiplier/divisor.
busy  output  1  high while an iterative operation is in flight.
done  output  1  one-cycle pulse when HI/LO have been updated.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0, any time, including mid-operation): state IDLE; busy=0, done=0, hi=0, lo=0; iteration counter and internal accumulators cleared. No partial result survives.
- States: IDLE, RUN, FINISH.
- Accept condition: start=1 and state IDLE on a rising edge (E0). If start=1 while busy, or op is not one of the six listed codes, the request is ignored with no state change and no done pulse.
- MTHI/MTLO at E0: hi<=a (or lo<=a); done=1 for the following cycle; busy stays 0; state stays IDLE. Back-to-back MTHI/MTLO on consecutive cycles are each accepted.
- MULT/DIV/MULTU/DIVU at E0:
  - Latch |a| and |b| for signed ops, raw a and b for unsigned ops.
  - Latch result-sign flags. Product and quotient signs are a[31]^b[31]; remainder sign is a[31]; both are 0 for unsigned ops.
  - Clear the counter; go to RUN; busy=1 from E0 onward.
- RUN: edges E1..E32 each perform one step and increment the counter.
  - Multiply: 64-bit shift-add.
  - Divide: restoring shift-subtract giving a WIDTH-bit quotient and remainder.
  - After the step at E32 (counter = WIDTH-1), go to FINISH.
- FINISH, edge E33:
  - Apply sign correction by two's-complement negation.
  - MULT*: hi<=product[63:32], lo<=product[31:0].
  - DIV*: lo<=quotient, hi<=remainder.
  - done=1 for exactly one cycle; busy<=0; state IDLE.
- Latency: hi/lo hold their old values throughout RUN and change only at E33. Result and done are visible 33 cycles after E0. A new start is accepted at E33 at the earliest; done and a new accept may coincide.
- Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Division by zero (no trap, fixed result, same 33-cycle latency):
  - DIVU: lo=32'hFFFFFFFF, hi=a.
  - DIV: lo=(a[31] ? 32'h00000001 : 32'hFFFFFFFF), hi=a.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Arithmetic: all products are the full 64 bits; no truncation before the HI/LO split.

Test Plan:
- MULTU a=FFFFFFFF b=FFFFFFFF, start at E0 -> busy high E0..E33; at E33 hi=FFFFFFFE, lo=00000001, done pulses once; hi/lo unchanged before E33.
- MULT a=FFFFFFFD(-3) b=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB; then DIV a=FFFFFFF9(-7) b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU a=00000005 b=0 -> lo=FFFFFFFF, hi=00000005 after 33 cycles; DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=00000000.
- MTHI a=12345678 then MTLO a=9ABCDEF0 on the next cycle -> hi/lo updated one edge after each request, two done pulses, busy never high.
- Start a MULTU, assert start with DIVU at E10 -> second request ignored; MULTU result unchanged; single done at E33.
- Start a DIV, drive reset=0 asynchronously at E15+half cycle -> busy, done, hi and lo go to 0 immediately; after release, an idle start is accepted normally.
